// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 key event decoder: prefix FSM, held-key tracking and a FWFT event FIFO.
// Defining KEY_REPEAT_EN adds auto-repeat while exactly one arrow key is held.
module ps2_key_event_decoder #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [2:0] ev_dir,
  output logic       ev_start,
  output logic [4:0] held,
  output logic [7:0] last_code,
  output logic       overflow,
  input  logic       clear_ovf
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e     state_q, state_d;
  logic       is_ignored, is_e0, is_f0;
  logic       code_done, code_brk;
  logic [4:0] key_hit;
  logic [3:0] key_ev;
  logic [4:0] held_d;
  logic       key_push;
  logic       push;
  logic [3:0] push_ev;

  always_comb begin
    is_ignored = rx_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1};
    is_e0      = (rx_data == 8'hE0);
    is_f0      = (rx_data == 8'hF0);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rx_valid && !is_ignored) begin
      if (is_e0) begin
        unique case (state_q)
          StIdle:  state_d = StExt;
          StBrk:   state_d = StExtBrk;
          default: state_d = state_q;
        endcase
      end else if (is_f0) begin
        unique case (state_q)
          StIdle:  state_d = StBrk;
          StExt:   state_d = StExtBrk;
          default: state_d = state_q;
        endcase
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    code_done = rx_valid && !is_ignored && !is_e0 && !is_f0;
    code_brk  = (state_q == StBrk) || (state_q == StExtBrk);
  end

  // Key map ignores the E0 prefix so numpad keys alias the arrow cluster.
  always_comb begin
    key_hit = '0;
    key_ev  = '0;
    unique case (rx_data)
      8'h75:   begin key_hit[0] = 1'b1; key_ev = 4'b0001; end
      8'h72:   begin key_hit[1] = 1'b1; key_ev = 4'b0010; end
      8'h6B:   begin key_hit[2] = 1'b1; key_ev = 4'b0011; end
      8'h74:   begin key_hit[3] = 1'b1; key_ev = 4'b0100; end
      8'h5A:   begin key_hit[4] = 1'b1; key_ev = 4'b1000; end
      default: ;
    endcase
  end

  always_comb begin
    held_d   = held;
    key_push = 1'b0;
    if (code_done) begin
      if (code_brk) begin
        held_d = held & ~key_hit;
      end else if ((key_hit & ~held) != '0) begin
        held_d   = held | key_hit;
        key_push = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      held      <= '0;
      last_code <= '0;
    end else begin
      held <= held_d;
      if (code_done) last_code <= rx_data;
    end
  end

`ifdef KEY_REPEAT_EN
  logic [31:0] rep_timer_q;
  logic        rep_armed_q;
  logic        one_arrow;
  logic        rep_fire;
  logic [3:0]  rep_ev;

  // A fire is never coincident with a fresh make because a make always changes held.
  always_comb begin
    one_arrow = $onehot(held[3:0]);
    rep_fire  = one_arrow && (held_d == held) &&
                (rep_timer_q == (rep_armed_q ? REPEAT_PERIOD - 1 : REPEAT_DELAY - 1));
    rep_ev    = '0;
    unique case (held[3:0])
      4'b0001: rep_ev = 4'b0001;
      4'b0010: rep_ev = 4'b0010;
      4'b0100: rep_ev = 4'b0011;
      4'b1000: rep_ev = 4'b0100;
      default: ;
    endcase
    push    = key_push | rep_fire;
    push_ev = key_push ? key_ev : rep_ev;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      rep_timer_q <= '0;
      rep_armed_q <= 1'b0;
    end else if ((held_d != held) || !one_arrow) begin
      rep_timer_q <= '0;
      rep_armed_q <= 1'b0;
    end else if (rep_fire) begin
      rep_timer_q <= '0;
      rep_armed_q <= 1'b1;
    end else begin
      rep_timer_q <= rep_timer_q + 32'd1;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};

  always_comb begin
    push    = key_push;
    push_ev = key_ev;
  end
`endif

  logic [3:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            fifo_full, do_pop, do_push;

  always_comb begin
    fifo_full           = (count_q == CntW'(FIFO_DEPTH));
    ev_valid            = (count_q != '0);
    do_pop              = ev_valid && ev_ready;
    do_push             = push && (!fifo_full || do_pop);
    {ev_start, ev_dir}  = ev_valid ? fifo_mem[rd_ptr_q] : 4'b0000;
  end

  always_ff @(posedge CLOCK_50) begin
    if (do_push) fifo_mem[wr_ptr_q] <= push_ev;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
      if (push && fifo_full && !do_pop) overflow <= 1'b1;
      else if (clear_ovf)               overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for ps2_key_event_decoder: directed scenarios plus random byte streams, all
// compared every cycle against a queue-based reference model of the key/event rules.
module tb_ps2_key_event_decoder;

  localparam int unsigned Depth     = 4;
  localparam int unsigned RepDelay  = 100;
  localparam int unsigned RepPeriod = 20;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       ev_ready = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       ev_valid;
  logic [2:0] ev_dir;
  logic       ev_start;
  logic [4:0] held;
  logic [7:0] last_code;
  logic       overflow;

  ps2_key_event_decoder #(
    .FIFO_DEPTH   (Depth),
    .REPEAT_DELAY (RepDelay),
    .REPEAT_PERIOD(RepPeriod)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_dir   (ev_dir),
    .ev_start (ev_start),
    .held     (held),
    .last_code(last_code),
    .overflow (overflow),
    .clear_ovf(clear_ovf)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  bit          chk_en  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: event queue of {start,dir}, held bits, break flag, age since held change.
  logic [3:0]  m_q[$];
  logic [4:0]  m_held;
  logic [7:0]  m_last;
  logic        m_ovf;
  bit          m_brk;
  int unsigned m_age;

  function automatic int key_index(input logic [7:0] b);
    case (b)
      8'h75:   return 0;
      8'h72:   return 1;
      8'h6B:   return 2;
      8'h74:   return 3;
      8'h5A:   return 4;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_held = '0;
    m_last = '0;
    m_ovf  = 1'b0;
    m_brk  = 1'b0;
    m_age  = 0;
  endtask

  task automatic model_step();
    bit         pop_now, want, drop;
    logic [3:0] ev;
    logic [4:0] prev;
    int         k;
    pop_now = (m_q.size() != 0) && ev_ready;
    want    = 1'b0;
    drop    = 1'b0;
    ev      = '0;
    prev    = m_held;
    if (rx_valid && !(rx_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1, 8'hE0})) begin
      if (rx_data == 8'hF0) begin
        m_brk = 1'b1;
      end else begin
        m_last = rx_data;
        k = key_index(rx_data);
        if (k >= 0) begin
          if (m_brk) m_held[k] = 1'b0;
          else if (!m_held[k]) begin
            m_held[k] = 1'b1;
            want      = 1'b1;
            ev        = (k == 4) ? 4'b1000 : 4'(k + 1);
          end
        end
        m_brk = 1'b0;
      end
    end
`ifdef KEY_REPEAT_EN
    if (m_held != prev) begin
      m_age = 0;
    end else begin
      m_age++;
      if ($countones(m_held[3:0]) == 1 &&
          (m_age == RepDelay || (m_age > RepDelay && (m_age - RepDelay) % RepPeriod == 0))) begin
        want = 1'b1;
        for (int a = 0; a < 4; a++) if (m_held[a]) ev = 4'(a + 1);
      end
    end
`endif
    if (want) begin
      if (m_q.size() == Depth && !pop_now) drop = 1'b1;
      else m_q.push_back(ev);
    end
    if (pop_now) void'(m_q.pop_front());
    if (drop) m_ovf = 1'b1;
    else if (clear_ovf) m_ovf = 1'b0;
  endtask

  always @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) model_reset();
    else model_step();
  end

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      check_eq("ev_valid", ev_valid, m_q.size() != 0);
      check_eq("ev_dir", ev_dir, (m_q.size() != 0) ? m_q[0][2:0] : 3'b000);
      check_eq("ev_start", ev_start, (m_q.size() != 0) ? m_q[0][3] : 1'b0);
      check_eq("held", held, m_held);
      check_eq("last_code", last_code, m_last);
      check_eq("overflow", overflow, m_ovf);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLOCK_50); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge CLOCK_50); #1;
    rx_valid = 1'b0;
  endtask

  // Strobe a byte with the consumer popping in the same cycle.
  task automatic send_byte_pop(input logic [7:0] b);
    @(posedge CLOCK_50); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    ev_ready = 1'b1;
    @(posedge CLOCK_50); #1;
    rx_valid = 1'b0;
    ev_ready = 1'b0;
  endtask

  task automatic release_all();
    logic [7:0] keys [5];
    keys = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A};
    for (int i = 0; i < 5; i++) begin
      send_byte(8'hF0);
      send_byte(keys[i]);
    end
  endtask

  logic [7:0] pool [15];
  logic [7:0] presses [6];
  int unsigned n_left, n_up;

  initial begin
    pool    = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'hE0, 8'hF0, 8'hF0,
                8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1, 8'h1C, 8'h29};
    presses = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h75};

    tick(2);
    chk_en = 1'b1;
    check_eq("rst_held", held, 5'b0);
    check_eq("rst_valid", ev_valid, 1'b0);
    check_eq("rst_last", last_code, 8'h00);
    resetn = 1'b1;

    // Reset mid-stream drops the pending E0 prefix.
    send_byte(8'hE0);
    resetn = 1'b0;
    tick(1);
    check_eq("midrst_held", held, 5'b0);
    check_eq("midrst_ovf", overflow, 1'b0);
    resetn = 1'b1;
    send_byte(8'h75);
    check_eq("midrst_up_held", held, 5'b00001);
    check_eq("midrst_up_dir", ev_dir, 3'b001);
    check_eq("midrst_last", last_code, 8'h75);
    ev_ready = 1'b1; tick(1); ev_ready = 1'b0;
    send_byte(8'hF0); send_byte(8'h75);

    // Extended press with consumer ready: visible one cycle after the final strobe.
    ev_ready = 1'b1;
    send_byte(8'hE0); send_byte(8'h75);
    check_eq("ext_up_valid", ev_valid, 1'b1);
    check_eq("ext_up_dir", ev_dir, 3'b001);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check_eq("ext_up_rel", held, 5'b0);
    tick(3);
    check_eq("ext_up_empty", ev_valid, 1'b0);
    ev_ready = 1'b0;

    // Host typematic of right arrow yields a single event.
    for (int i = 0; i < 5; i++) begin
      send_byte(8'hE0); send_byte(8'h74);
      check_eq("typ_held", held[3], 1'b1);
    end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    check_eq("typ_rel", held[3], 1'b0);
    check_eq("typ_dir", ev_dir, 3'b100);
    ev_ready = 1'b1; tick(1); ev_ready = 1'b0;
    check_eq("typ_single", ev_valid, 1'b0);

    // Enter and keypad-enter alias.
    send_byte(8'h5A);
    check_eq("ent_start", ev_start, 1'b1);
    check_eq("ent_dir", ev_dir, 3'b000);
    ev_ready = 1'b1; tick(1); ev_ready = 1'b0;
    send_byte(8'hE0); send_byte(8'h5A);
    tick(1);
    check_eq("ent_alias", ev_valid, 1'b0);
    send_byte(8'hF0); send_byte(8'h5A);

    // Overflow: six presses into a four-deep FIFO with no consumer.
    for (int i = 0; i < 6; i++) begin
      send_byte(presses[i]);
      if (i != 5) begin send_byte(8'hF0); send_byte(presses[i]); end
    end
    check_eq("ovf_set", overflow, 1'b1);
    check_eq("ovf_head", ev_dir, 3'b001);
    @(posedge CLOCK_50); #1; clear_ovf = 1'b1;
    @(posedge CLOCK_50); #1; clear_ovf = 1'b0;
    check_eq("ovf_clear", overflow, 1'b0);
    send_byte(8'hF0); send_byte(8'h75);
    send_byte_pop(8'h72);
    check_eq("full_pushpop_ovf", overflow, 1'b0);
    check_eq("full_pushpop_head", ev_dir, 3'b010);
    ev_ready = 1'b1; tick(6); ev_ready = 1'b0;
    check_eq("drained", ev_valid, 1'b0);
    release_all();

`ifdef KEY_REPEAT_EN
    ev_ready = 1'b1;
    send_byte(8'h6B);
    n_left = 0;
    repeat (160) begin
      @(negedge CLOCK_50);
      if (ev_valid && ev_dir == 3'b011) n_left++;
    end
    check_eq("rep_left_count", n_left, 4);
    send_byte(8'hE0); send_byte(8'h75);
    n_left = 0;
    n_up   = 0;
    repeat (150) begin
      @(negedge CLOCK_50);
      if (ev_valid && ev_dir == 3'b011) n_left++;
      if (ev_valid && ev_dir == 3'b001) n_up++;
    end
    check_eq("rep_two_left", n_left, 0);
    check_eq("rep_two_up", n_up, 1);
    ev_ready = 1'b0;
    release_all();
    ev_ready = 1'b1; tick(8); ev_ready = 1'b0;
`endif

    // Random byte stream, random back-pressure and clears.
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLOCK_50); #1;
      rx_valid  = ($urandom_range(0, 2) == 0);
      rx_data   = pool[$urandom_range(0, 14)];
      ev_ready  = ($urandom_range(0, 1) == 1);
      clear_ovf = ($urandom_range(0, 19) == 0);
    end
    rx_valid  = 1'b0;
    clear_ovf = 1'b0;
    tick(4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_decoder.md
Name: ps2_key_event_decoder

Overview:
Parametrised successor to the keyboard decoder. Consumes the byte stream from PS2_Controller (received_data / received_data_en) and runs a full PS/2 set-2 prefix state machine (E0 extended, F0 break). It tracks held state for up, down, left, right and enter, and emits one discrete move/start event per key press into a small FIFO with a valid/ready handshake. gameLogic pops one event per move, so no press is lost or double-counted.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of 2, minimum 2
REPEAT_DELAY, 25000000, cycles from press to first auto-repeat (KEY_REPEAT_EN only)
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeats (KEY_REPEAT_EN only)

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  asynchronous active-low reset
rx_data  in  8  scancode byte from PS2_Controller received_data
rx_valid  in  1  one-cycle strobe, from received_data_en
ev_valid  out  1  FIFO head holds an event
ev_ready  in  1  consumer accepts the head event on a cycle where ev_valid && ev_ready
ev_dir  out  3  head direction: 000 none, 001 up, 010 down, 011 left, 100 right
ev_start  out  1  head is an enter/start event (ev_dir = 000)
held  out  5  level key state {enter,right,left,down,up}
last_code  out  8  last completed code byte, for HEX debug
overflow  out  1  sticky: an event was dropped because the FIFO was full
clear_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset, async, resetn=0: state S_IDLE; FIFO empty; ev_valid=0, ev_dir=000, ev_start=0, held=0, last_code=00, overflow=0; repeat timer=0.
- Prefix FSM advances only on cycles with rx_valid=1.
  - S_IDLE: E0->S_EXT; F0->S_BRK.
  - S_EXT: F0->S_EXT_BRK.
  - S_BRK: E0->S_EXT_BRK.
  - In any state, any other byte completes a code and returns to S_IDLE.
  - E0 in S_EXT or S_EXT_BRK, and F0 in S_BRK or S_EXT_BRK: state unchanged.
  - Bytes AA, FA, FE, EE, E1 are ignored in every state: no state change, no last_code update.
- Key map, prefix-insensitive: 75 up, 72 down, 6B left, 74 right, 5A enter. E0 is accepted but not required, so numpad and keypad-enter alias.
- Completed make of a mapped key whose held bit is 0: set held bit; push event. Arrow pushes dir code with start=0; enter pushes dir=000, start=1.
- Completed make of a mapped key already held (host typematic): no push.
- Completed break: clear held bit; no push.
- Unmapped completed codes: last_code updated; held unchanged; no push.
- Latency: final byte strobe at cycle n -> held, last_code and FIFO write at the edge ending cycle n. If the FIFO was empty, ev_valid=1 in cycle n+1.
- FIFO: first-word fall-through; ev_dir/ev_start valid whenever ev_valid=1; outputs 000/0 when empty.
  - Push when full with no pop in the same cycle: event dropped, overflow<=1.
  - Push and pop in the same cycle when full: both succeed; count unchanged.
  - Push and pop in the same cycle when empty: push only (no fall-through bypass).
  - Pointers wrap modulo FIFO_DEPTH.
- clear_ovf=1 clears overflow. An overflow set in the same cycle wins.
- held is independent of the FIFO; a dropped event still updates held.

Optional Feature:
KEY_REPEAT_EN
- Defined: an internal timer auto-repeats while exactly one arrow bit of held is set.
  - Timer restarts at 0 on any held change.
  - At REPEAT_DELAY, then every REPEAT_PERIOD cycles, push that arrow's event. Overflow rules as above.
  - Enter never repeats.
  - Two or more arrows held: timer held at 0.
- Not defined: no timer logic; REPEAT_* parameters unused; only fresh makes push events.

Test Plan:
- Reset mid-stream: drive E0, pulse resetn low, then send 75 -> up pushed as a non-extended press; state was S_IDLE after reset; all outputs at reset values while resetn=0.
- E0 75, ev_ready=1 -> ev_valid=1 one cycle after the 75 strobe, ev_dir=001, held=00001. Then E0 F0 75 -> held=00000, no second event.
- Host typematic E0 74 repeated 5x, then E0 F0 74 -> exactly one event, dir=100; held[3] high from the first make until the break.
- 5A -> ev_start=1, ev_dir=000. Then E0 5A while 5A is still held -> no event.
- ev_ready=0, FIFO_DEPTH=4, six distinct presses -> first 4 events retained in order, overflow=1. A pop in the same cycle as a push while full -> count stays 4, no drop. clear_ovf -> overflow=0.
- KEY_REPEAT_EN with REPEAT_DELAY=100, REPEAT_PERIOD=20: hold 6B for 160 cycles -> events at press, +100, +120, +140. Also pressing 75 during the hold -> timer stops.
